// File: rtl/fetch_if.sv
// Fetch-stage bundle: pipeline control in, instruction memory port, IF/ID register out.
// FETCH_PERF_CNT_EN adds the fetch/bubble performance counter outputs.
interface fetch_if;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        if_valid;
  logic        halted;
  logic        fault;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_count;
  logic [15:0] bubble_count;

  modport master (
    input  stall, branch_taken, branch_target, imem_data,
    output imem_addr, if_instr, if_pc, if_valid, halted, fault,
    output fetch_count, bubble_count
  );
  modport slave (
    output stall, branch_taken, branch_target, imem_data,
    input  imem_addr, if_instr, if_pc, if_valid, halted, fault,
    input  fetch_count, bubble_count
  );
`else
  modport master (
    input  stall, branch_taken, branch_target, imem_data,
    output imem_addr, if_instr, if_pc, if_valid, halted, fault
  );
  modport slave (
    output stall, branch_taken, branch_target, imem_data,
    input  imem_addr, if_instr, if_pc, if_valid, halted, fault
  );
`endif
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, fills IF/ID, handles stall/redirect/halt/range fault.
// Optional FETCH_PERF_CNT_EN adds saturating fetch_count/bubble_count outputs.
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int          MEM_DEPTH = 27,
  parameter logic [15:0] HALT_WORD = 16'hEBCF
) (
  input logic     clk,
  input logic     rst,
  fetch_if.master bus
);
  typedef enum logic [1:0] {BOOT, RUN, HALT, FAULT} state_t;

  localparam logic [16:0] DEPTH_LIM = 17'(MEM_DEPTH);

  state_t      state_reg, state_next;
  logic [15:0] pc_reg, pc_next;
  logic [15:0] instr_reg, instr_next;
  logic [15:0] ipc_reg, ipc_next;
  logic        valid_reg, valid_next;
  logic        halted_reg, halted_next;
  logic        fault_reg, fault_next;
  logic [15:0] word_idx;
  logic [15:0] redirect_pc;
  logic        in_range;
  logic        unused_tgt_lsb;

  assign word_idx    = {1'b0, pc_reg[15:1]};
  assign in_range    = ({1'b0, word_idx} < DEPTH_LIM);
  assign redirect_pc = {bus.branch_target[15:1], 1'b0};
  // Target bit 0 is discarded: instructions are always halfword aligned.
  assign unused_tgt_lsb = bus.branch_target[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= BOOT;
      pc_reg     <= RESET_PC;
      instr_reg  <= 16'h0000;
      ipc_reg    <= 16'h0000;
      valid_reg  <= 1'b0;
      halted_reg <= 1'b0;
      fault_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      instr_reg  <= instr_next;
      ipc_reg    <= ipc_next;
      valid_reg  <= valid_next;
      halted_reg <= halted_next;
      fault_reg  <= fault_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    instr_next  = instr_reg;
    ipc_next    = ipc_reg;
    valid_next  = valid_reg;
    halted_next = halted_reg;
    fault_next  = fault_reg;
    case (state_reg)
      BOOT: state_next = RUN;
      RUN: begin
        if (bus.branch_taken) begin
          pc_next    = redirect_pc;
          valid_next = 1'b0;
        end else if (bus.stall) begin
          valid_next = valid_reg;
        end else if (!in_range) begin
          fault_next = 1'b1;
          valid_next = 1'b0;
          state_next = FAULT;
        end else begin
          instr_next = bus.imem_data;
          ipc_next   = pc_reg;
          valid_next = 1'b1;
          // The PC parks on the halt word so a later redirect is the only way on.
          if (bus.imem_data == HALT_WORD) begin
            halted_next = 1'b1;
            state_next  = HALT;
          end else begin
            pc_next = pc_reg + 16'd2;
          end
        end
      end
      HALT: begin
        if (bus.branch_taken) begin
          pc_next     = redirect_pc;
          valid_next  = 1'b0;
          halted_next = 1'b0;
          state_next  = RUN;
        end else if (!(bus.stall && valid_reg)) begin
          valid_next = 1'b0;
        end
      end
      FAULT: begin
        if (bus.branch_taken) begin
          pc_next    = redirect_pc;
          fault_next = 1'b0;
          state_next = RUN;
        end
      end
      default: state_next = BOOT;
    endcase
  end

  assign bus.imem_addr = word_idx;
  assign bus.if_instr  = instr_reg;
  assign bus.if_pc     = ipc_reg;
  assign bus.if_valid  = valid_reg;
  assign bus.halted    = halted_reg;
  assign bus.fault     = fault_reg;

`ifdef FETCH_PERF_CNT_EN
  logic [1:0]  cnt_inc;
  logic [15:0] cnt_reg [2];

  // Index 0 counts real fetches; index 1 counts every other RUN/HALT edge.
  assign cnt_inc[0] = (state_reg == RUN) && !bus.branch_taken && !bus.stall && in_range;
  assign cnt_inc[1] = (state_reg == HALT) || ((state_reg == RUN) && !cnt_inc[0]);

  for (genvar gi = 0; gi < 2; gi++) begin : g_perf
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_reg[gi] <= 16'h0000;
      end else if (cnt_inc[gi] && (cnt_reg[gi] != 16'hFFFF)) begin
        cnt_reg[gi] <= cnt_reg[gi] + 16'd1;
      end
    end
  end

  assign bus.fetch_count  = cnt_reg[0];
  assign bus.bubble_count = cnt_reg[1];
`endif
endmodule
